// File: rtl/sparse_index_scheduler.sv
// Walks a 32-bit mask highest-set-bit first, issuing one index beat per cycle
// over valid/ready; each mask's tag rides on all of its beats.
module sparse_index_scheduler #(
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_mask,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_idx,
   output logic [TAG_W-1:0] out_tag,
   output logic [4:0]       out_seq,
   output logic             out_last,
   output logic             out_empty,
   output logic             busy
);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t           state_q, state_d;
   logic [31:0]      mask_q, mask_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [4:0]       seq_q, seq_d;
   logic             empty_q, empty_d;

   logic [5:0]  lz;
   logic [31:0] mask_clr;
   logic        issuing, hs, last_w, accept;

   // Leading-zero count, 32 for an all-zero word.
   function automatic logic [5:0] leading_zero32(input logic [31:0] v);
      logic [5:0] n;
      n = 6'd32;
      for (int i = 0; i < 32; i++)
         if (v[i]) n = 6'(31 - i);
      return n;
   endfunction

   always_comb begin
      lz       = leading_zero32(mask_q);
      issuing  = (state_q == ISSUE);
      // Gate to 0 when idle or empty: the raw 31-lz wraps to 31 on a zero mask.
      out_idx  = (issuing && !empty_q) ? 5'(6'd31 - lz) : 5'd0;
      mask_clr = mask_q & ~(32'd1 << out_idx);
      last_w   = issuing & (empty_q | (mask_clr == 32'd0));
      hs       = issuing & out_ready;
      in_ready = !reset & (!issuing | (hs & last_w));
      accept   = in_valid & in_ready;
   end

   assign out_valid = issuing;
   assign out_tag   = tag_q;
   assign out_seq   = seq_q;
   assign out_last  = last_w;
   assign out_empty = empty_q & issuing;
   assign busy      = issuing;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      tag_d   = tag_q;
      seq_d   = seq_q;
      empty_d = empty_q;
      if (accept) begin
         // Covers both the idle load and the bubble-free reload on a last beat.
         state_d = ISSUE;
         mask_d  = in_mask;
         tag_d   = in_tag;
         seq_d   = 5'd0;
         empty_d = (in_mask == 32'd0);
      end else if (hs) begin
         if (last_w) begin
            state_d = IDLE;
            mask_d  = 32'd0;
            empty_d = 1'b0;
         end else begin
            mask_d = mask_clr;
            seq_d  = seq_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mask_q  <= 32'd0;
         tag_q   <= '0;
         seq_q   <= 5'd0;
         empty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         tag_q   <= tag_d;
         seq_q   <= seq_d;
         empty_q <= empty_d;
      end
   end

endmodule
